// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared FSM state encoding for the timer controller.
package timer_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_busy(state_t s);
    return s == RUN || s == HOLD;
  endfunction
endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: control inputs and status outputs of the timer controller.
interface timer_ctrl_if #(parameter int WIDTH = 3);
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic [1:0]       state;
  modport master (output start, pause, abort, period, input count, busy, tc, state);
  modport slave  (input start, pause, abort, period, output count, busy, tc, state);
endinterface

// File: rtl/timer_ctrl_ctr_core.sv
// ctr_core: WIDTH-bit up-counter with synchronous clear (priority) and enable.
module ctr_core #(parameter int WIDTH = 3) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk)
    r_count <= i_clr ? '0 : i_en ? r_count + 1'b1 : r_count;
  assign o_count = r_count;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: start/pause/abort timer FSM with terminal-count pulse.
// Define TIMER_CTRL_AUTORELOAD_EN to keep running and repeat tc instead of stopping in DONE.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input logic         clk,
  input logic         reset,
  timer_ctrl_if.slave bus
);
`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam state_t TERM_NEXT = RUN;
`else
  localparam state_t TERM_NEXT = DONE;
`endif
  state_t           r_state;
  logic [WIDTH-1:0] r_period;
  logic             r_tc;
  logic [WIDTH-1:0] w_count;
  logic             w_start;
  logic             w_term;
  logic             w_clr;
  logic             w_en;
  assign w_start = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_term  = r_state == RUN && w_count == r_period;
  assign w_clr   = reset || bus.abort || w_start || w_term;
  // the resume edge out of HOLD also counts, so each paused cycle delays tc by exactly one
  assign w_en    = !bus.pause && (r_state == RUN || r_state == HOLD);
  ctr_core #(.WIDTH(WIDTH)) u_ctr (
    .clk    (clk),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(w_count)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state  <= IDLE;
      r_period <= '0;
      r_tc     <= 1'b0;
    end else if (bus.abort) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_tc     <= w_term;
      r_period <= w_start ? bus.period : r_period;
      r_state  <= w_start ? RUN :
                  w_term ? TERM_NEXT :
                  (r_state == RUN && bus.pause) ? HOLD :
                  (r_state == HOLD && !bus.pause) ? RUN : r_state;
    end
  assign bus.count = w_count;
  assign bus.tc    = r_tc;
  assign bus.state = r_state;
  assign bus.busy  = is_busy(r_state);
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed stimulus, tick-based reference model and literal spot checks.
module tb_timer_ctrl;
`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int TERM_ST = AUTO ? 1 : 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  timer_ctrl_if #(.WIDTH(3)) bus ();
  timer_ctrl #(.WIDTH(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: ticks = productive edges since start; count is ticks mod (period+1),
  // a terminal edge is the one that completes a full period+1 ticks.
  int m_ph, m_ticks, m_per;
  bit m_tc, m_valid;
  logic m_term;
  int m_cnt;
  always_comb begin
    m_term = m_ph == 1 && (m_ticks % (m_per + 1)) == m_per;
    m_cnt = (m_ph == 1 || m_ph == 2) ? m_ticks % (m_per + 1) : 0;
  end
  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_ph <= 0;
      m_ticks <= 0;
      m_per <= 0;
      m_tc <= 1'b0;
    end else if (bus.abort) begin
      m_ph <= 0;
      m_ticks <= 0;
      m_tc <= 1'b0;
    end else if ((m_ph == 0 || m_ph == 3) && bus.start) begin
      m_ph <= 1;
      m_ticks <= 0;
      m_per <= int'(bus.period);
      m_tc <= 1'b0;
    end else if (m_ph == 1 || m_ph == 2) begin
      m_tc <= m_term;
      if (m_term) begin
        m_ticks <= m_ticks + 1;
        m_ph <= AUTO ? 1 : 3;
      end else if (bus.pause) m_ph <= 2;
      else begin
        m_ticks <= m_ticks + 1;
        m_ph <= 1;
      end
    end else m_tc <= 1'b0;
  end
  always @(negedge clk)
    if (m_valid) begin
      chk("state", int'(bus.state), m_ph);
      chk("count", int'(bus.count), m_cnt);
      chk("busy", int'(bus.busy), (m_ph == 1 || m_ph == 2) ? 1 : 0);
      chk("tc", int'(bus.tc), int'(m_tc));
    end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(int p);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.period = 3'(p);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    int tcs;
    bus.start = 1'b1;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.period = 3'd5;
    tick();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tc", int'(bus.tc), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    tick(2);
    chk("idle_state", int'(bus.state), 0);
    go(5);
    chk("os_state", int'(bus.state), 1);
    chk("os_count0", int'(bus.count), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("os_count", int'(bus.count), i);
      chk("os_tc_low", int'(bus.tc), 0);
    end
    tick();
    chk("os_tc", int'(bus.tc), 1);
    chk("os_done", int'(bus.state), TERM_ST);
    chk("os_busy", int'(bus.busy), int'(AUTO));
    tick();
    chk("os_tc_once", int'(bus.tc), 0);
    go(0);
    chk("p0_count", int'(bus.count), 0);
    tick();
    chk("p0_tc", int'(bus.tc), 1);
    chk("p0_state", int'(bus.state), TERM_ST);
    go(6);
    tick(3);
    chk("pz_count3", int'(bus.count), 3);
    bus.pause = 1'b1;
    repeat (4) begin
      tick();
      chk("pz_hold", int'(bus.state), 2);
      chk("pz_frozen", int'(bus.count), 3);
    end
    bus.pause = 1'b0;
    tick(3);
    chk("pz_count6", int'(bus.count), 6);
    chk("pz_tc_late", int'(bus.tc), 0);
    tick();
    chk("pz_tc", int'(bus.tc), 1);
    go(5);
    tick(2);
    chk("ab_count2", int'(bus.count), 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("ab_state", int'(bus.state), 0);
    chk("ab_count", int'(bus.count), 0);
    chk("ab_tc", int'(bus.tc), 0);
    repeat (8) begin
      tick();
      chk("ab_no_tc", int'(bus.tc), 0);
    end
    go(3);
    bus.period = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ign_count1", int'(bus.count), 1);
    tick(2);
    chk("ign_count3", int'(bus.count), 3);
    tick();
    chk("ign_tc", int'(bus.tc), 1);
    go(4);
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_state", int'(bus.state), 0);
    chk("mr_count", int'(bus.count), 0);
    repeat (6) begin
      tick();
      chk("mr_no_tc", int'(bus.tc), 0);
    end
    go(7);
    tcs = 0;
    repeat (24) begin
      tick();
      tcs += int'(bus.tc);
    end
    chk("ar_tc_count", tcs, AUTO ? 3 : 1);
    chk("ar_busy", int'(bus.busy), int'(AUTO));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ar_abort_busy", int'(bus.busy), 0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the counter and period width in bits.
REQ-002 Port clk SHALL be: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port start SHALL be: start  input  1  one-cycle request to begin a timing run.
REQ-005 Port pause SHALL be: pause  input  1  level; freezes the count while high.
REQ-006 Port abort SHALL be: abort  input  1  cancels any run and returns to idle.
REQ-007 Port period SHALL be: period  input  WIDTH  terminal count, sampled only on an accepted start.
REQ-008 Port count SHALL be: count  output  WIDTH  current count value, registered.
REQ-009 Port busy SHALL be: busy  output  1  high while in RUN or HOLD.
REQ-010 Port tc SHALL be: tc  output  1  registered one-cycle terminal-count pulse.
REQ-011 Port state SHALL be: state  output  2  FSM state encoding.

Function
REQ-012 The FSM SHALL have states IDLE=0, RUN=1, HOLD=2 and DONE=3.
REQ-013 In IDLE or DONE, start=1 SHALL do all of the following at that edge:
- latch period into period_q;
- clear count to 0;
- enter RUN.
REQ-014 In RUN with count!=period_q and pause=0, count SHALL increment by 1 per cycle.
REQ-015 In RUN with count==period_q, the edge SHALL do all of the following:
- set tc=1 for exactly one cycle;
- clear count to 0;
- change state as set by REQ-024 and REQ-025.
REQ-016 The terminal check in RUN SHALL take priority over pause in the same cycle; pause then applies from the next cycle.
REQ-017 In RUN with pause=1 and count!=period_q, the block SHALL enter HOLD with count frozen.
REQ-018 In HOLD, count SHALL hold its value, and pause=0 SHALL return the block to RUN.
REQ-019 start SHALL be ignored in RUN and HOLD; period changes SHALL NOT affect a run in progress.
REQ-020 abort=1 SHALL take effect in any state, with priority over start and pause:
- go to IDLE;
- clear count to 0;
- force tc=0.
REQ-021 period=0 SHALL produce tc exactly one cycle after the start edge.
REQ-022 Latency SHALL be: for period P with no pause, tc is high in the cycle P+1 edges after the start edge.
REQ-023 busy SHALL be combinational from state; count, tc and state SHALL be registered.

Reset
REQ-024 (see Configuration) Without auto-reload, a terminal edge SHALL enter DONE.
REQ-026 reset=1 SHALL take priority over all inputs at the clock edge and set:
- state=IDLE;
- count=0;
- period_q=0;
- tc=0;
- busy=0.
REQ-027 A reset asserted mid-run SHALL discard the run with no tc pulse.

Configuration
REQ-025 With macro TIMER_CTRL_AUTORELOAD_EN defined, a terminal edge SHALL keep the state in RUN and reuse period_q, so tc repeats every period_q+1 cycles until abort or reset.
REQ-028 With TIMER_CTRL_AUTORELOAD_EN undefined, the block SHALL be one-shot: DONE holds count=0 and busy=0 until start or abort.
REQ-029 The port list SHALL be identical with and without the macro.

Structure
REQ-030 A shared package timer_ctrl_pkg SHALL hold:
- the 2-bit state typedef;
- the IDLE/RUN/HOLD/DONE constants.
REQ-031 The count register SHALL be a sub-module ctr_core, a WIDTH-bit up-counter with synchronous clear and enable, driven by the FSM.

Verification (WIDTH=3)
REQ-032 Reset: assert reset with start=1 -> state=0, count=0, busy=0, tc=0.
REQ-033 One-shot: period=5, start pulse -> count 0..5 on successive cycles, tc high exactly one cycle 6 edges after start, then state=3, busy=0.
REQ-034 Zero period: period=0, start -> tc high one cycle after start, then state=3.
REQ-035 Pause: period=6, pause high for 4 cycles at count=3 -> state=2 and count=3 held, tc delayed by exactly 4 cycles.
REQ-036 Abort: abort and start together at count=2 -> state=0, count=0, no tc pulse.
REQ-037 Auto-reload (macro defined): period=7 -> tc every 8 cycles, count wraps 7->0, busy stays 1 until abort.
